key_action_decoder: RTL
=======================

# key_action_decoder

Multi-player keyboard action decoder between the USB keycode registers and the game-logic/sprite controllers. Sampled once per frame, it matches the six-slot keycode bus against a per-player keymap, resolves left/right conflicts by last-pressed-wins, and emits one-cycle jump pulses and cooldown-gated attack pulses. It generalises the single-player combinational key decode to N players with per-frame edge detection and attack rate limiting.

## Interface
- NUM_PLAYERS, 2, number of independent player channels
- NUM_SLOTS, 6, 8-bit keycode slots on the keycode bus
- COOLDOWN_FRAMES, 15, frames after an attack before the next attack is accepted (0 = no cooldown)
- KEYMAP, {8'h28,8'h52,8'h4F,8'h50, 8'h1A,8'h2C,8'h07,8'h04}, NUM_PLAYERS*4*8 bits; entry for player p, action a at [(p*4+a)*8 +: 8]; actions LEFT=0, RIGHT=1, JUMP=2, ATTACK=3; defaults P0 A/D/Space/W, P1 Left/Right/Up/Enter
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-Clk-cycle pulse per frame, already synchronised to Clk
- keycodes  in  NUM_SLOTS*8  slot k at [k*8 +: 8]; 8'h00 = empty slot
- move_l  out  NUM_PLAYERS  player p moving left (level)
- move_r  out  NUM_PLAYERS  player p moving right (level)
- jump_pulse  out  NUM_PLAYERS  one-cycle pulse on jump key press
- attack_pulse  out  NUM_PLAYERS  one-cycle pulse on accepted attack
- attack_ready  out  NUM_PLAYERS  player p cooldown counter is zero

## Operation
- Match (combinational): hit[p][a] = OR over slots of (slot == KEYMAP entry) AND entry != 8'h00. A zero keymap entry disables that action. Duplicate keycodes in several slots count once.
- Sampling: on Clk edge with frame_tick=1: cur <= hit, prev <= cur. No other cycle changes cur/prev. rise[p][a] = cur & ~prev, evaluated against the newly sampled value in the same update.
- Direction FSM per player, states DIR_NONE, DIR_L, DIR_R, evaluated only on frame_tick with new L/R levels:
  - only L held -> DIR_L; only R held -> DIR_R; neither -> DIR_NONE.
  - both held: L rose and R did not -> DIR_L; R rose and L did not -> DIR_R; otherwise hold current state (including DIR_NONE).
- move_l = (state==DIR_L), move_r = (state==DIR_R); never both high.
- Jump: jump_pulse[p] high for exactly one Clk cycle when JUMP rises on a tick; holding does not repeat.
- Attack cooldown: per-player counter cd, width $clog2(COOLDOWN_FRAMES+1) (min 1). On tick: if cd==0 and ATTACK rises -> attack_pulse for one cycle, cd <= COOLDOWN_FRAMES; else if cd>0 -> cd <= cd-1. Presses during cooldown are discarded, not queued. attack_ready = (cd==0).
- Players are fully independent; no cross-player priority.

## Timing
- All outputs registered except attack_ready (decoded from cd register). Latency: outputs update on the Clk edge at which frame_tick is sampled high; visible the following cycle. Keycode changes between ticks are invisible.
- Pulses last exactly one Clk cycle per tick, even if frame_tick is held high on consecutive cycles (each high cycle is a tick; back-to-back ticks with a key held produce one rise only).
- Reset: cur, prev = 0; state DIR_NONE; cd = 0; move_l, move_r, jump_pulse, attack_pulse = 0; attack_ready = 1. frame_tick during Reset ignored. A key held across reset release produces a rise on the first tick after reset.
- Cooldown example (15): fire at tick T; attack_ready low T..T+14 after-update, high after tick T+15; rise at tick T+15 is discarded (cd was 1), rise at T+16 fires.

## Structure
- Package key_pkg: action index constants (ACT_LEFT..ACT_ATTACK), NUM_ACTIONS=4, dir_t enum, default keycode constants.
- Sub-module key_player_channel (one per player, generate loop): cur/prev registers, direction FSM, jump edge, cooldown counter. Top holds keymap match and slot OR-reduction.

## Test plan
- P0 keycodes {04} at tick 1, cleared at tick 3 -> move_l[0]=1 from tick 1 through tick 2 update, 0 after tick 3; move_r=0 throughout.
- P0 hold 04, at tick 2 add 07 -> DIR_R; release 07 at tick 4 -> DIR_L; 04 and 07 both rising on same tick from idle -> both moves stay 0.
- P0 tap 1A at tick 0, hold through tick 20 -> exactly one attack_pulse; re-press at tick 15 discarded, re-press rising at tick 16 fires second pulse.
- P1 jump 52 held 10 ticks while P0 attacks with 1A in slot 5 -> one jump_pulse[1], one attack_pulse[0], no cross-talk.
- Assert Reset mid-cooldown (cd=7) with 04 held -> all outputs reset, attack_ready=1; first tick after reset gives move_l[0]=1.
- COOLDOWN_FRAMES=0, KEYMAP ATTACK entry 00 for P1 -> P0 fires on every rising edge; P1 never attacks even with 00 slots.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the multi-player keyboard action decoder:
//   - action indices into each player's 4-entry keymap slice
//   - direction state encoding for the per-player left/right resolver
//   - default USB HID keycodes and the default two-player keymap
//   - helper that sizes the attack cooldown counter
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int NUM_ACTIONS = 4;
    localparam int ACT_LEFT    = 0;
    localparam int ACT_RIGHT   = 1;
    localparam int ACT_JUMP    = 2;
    localparam int ACT_ATTACK  = 3;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_t;

    // USB HID usage codes used by the default keymap
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_UP    = 8'h52;

    // Entry for player p, action a lives at [(p*4+a)*8 +: 8]
    localparam logic [63:0] DEFAULT_KEYMAP = {
        KEY_ENTER, KEY_UP, KEY_RIGHT, KEY_LEFT,   // player 1
        KEY_W, KEY_SPACE, KEY_D, KEY_A            // player 0
    };

    // Cooldown counter width; a zero cooldown still needs a 1-bit register
    function automatic int cd_width(input int frames);
        return (frames > 0) ? $clog2(frames + 1) : 1;
    endfunction

endpackage

// File: rtl/key_action_decoder_if.sv
// -----------------------------------------------------------------------------
// key_action_decoder_if
// Bundles the keycode bus and the per-player action outputs.
//   frame_tick   : one-cycle pulse per frame (master -> decoder)
//   keycodes     : NUM_SLOTS x 8-bit keycodes, slot k at [k*8 +: 8]
//   move_l/move_r: per-player direction levels
//   jump_pulse   : per-player one-cycle jump pulse
//   attack_pulse : per-player one-cycle accepted-attack pulse
//   attack_ready : per-player cooldown-expired level
// Modports: master (keycode source / game logic), slave (decoder).
// -----------------------------------------------------------------------------
interface key_action_decoder_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SLOTS   = 6
);
    logic                     frame_tick;
    logic [NUM_SLOTS*8-1:0]   keycodes;
    logic [NUM_PLAYERS-1:0]   move_l;
    logic [NUM_PLAYERS-1:0]   move_r;
    logic [NUM_PLAYERS-1:0]   jump_pulse;
    logic [NUM_PLAYERS-1:0]   attack_pulse;
    logic [NUM_PLAYERS-1:0]   attack_ready;

    modport master (
        output frame_tick, keycodes,
        input  move_l, move_r, jump_pulse, attack_pulse, attack_ready
    );

    modport slave (
        input  frame_tick, keycodes,
        output move_l, move_r, jump_pulse, attack_pulse, attack_ready
    );
endinterface

// File: rtl/key_player_channel.sv
// -----------------------------------------------------------------------------
// key_player_channel
// Per-player frame-sampled action logic.
//   clk_i          : system clock
//   srst_i         : synchronous active-high reset
//   tick_i         : frame tick; the only cycles on which state advances
//   hit_i          : combinational key matches, one bit per action
//   move_l_o       : direction resolver is in DIR_L
//   move_r_o       : direction resolver is in DIR_R
//   jump_pulse_o   : one-cycle pulse when JUMP rises on a tick
//   attack_pulse_o : one-cycle pulse when ATTACK rises with cooldown idle
//   attack_ready_o : cooldown counter is zero
// -----------------------------------------------------------------------------
module key_player_channel
    import key_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   tick_i,
    input  logic [NUM_ACTIONS-1:0] hit_i,
    output logic                   move_l_o,
    output logic                   move_r_o,
    output logic                   jump_pulse_o,
    output logic                   attack_pulse_o,
    output logic                   attack_ready_o
);

    localparam int              CD_W    = cd_width(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    logic [NUM_ACTIONS-1:0] cur_q, cur_d;
    dir_t                   state_q, state_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic                   jump_q, jump_d;
    logic                   attack_q, attack_d;
    logic [NUM_ACTIONS-1:0] rise;

    // cur_q holds last frame's levels, so comparing the incoming sample with
    // it gives the edge in the same update that captures the new level.
    assign rise = hit_i & ~cur_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cur_q    <= '0;
            state_q  <= DIR_NONE;
            cd_q     <= '0;
            jump_q   <= 1'b0;
            attack_q <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            state_q  <= state_d;
            cd_q     <= cd_d;
            jump_q   <= jump_d;
            attack_q <= attack_d;
        end
    end

    always_comb begin
        cur_d    = cur_q;
        state_d  = state_q;
        cd_d     = cd_q;
        jump_d   = 1'b0;
        attack_d = 1'b0;
        if (tick_i) begin
            cur_d  = hit_i;
            jump_d = rise[ACT_JUMP];

            unique case ({hit_i[ACT_LEFT], hit_i[ACT_RIGHT]})
                2'b10:   state_d = DIR_L;
                2'b01:   state_d = DIR_R;
                2'b00:   state_d = DIR_NONE;
                default: begin
                    // Both held: the freshly pressed side wins; a tie holds.
                    if (rise[ACT_LEFT] && !rise[ACT_RIGHT]) begin
                        state_d = DIR_L;
                    end else if (rise[ACT_RIGHT] && !rise[ACT_LEFT]) begin
                        state_d = DIR_R;
                    end
                end
            endcase

            // Presses while counting down are dropped, never queued.
            if ((cd_q == '0) && rise[ACT_ATTACK]) begin
                attack_d = 1'b1;
                cd_d     = CD_LOAD;
            end else if (cd_q != '0) begin
                cd_d = cd_q - CD_ONE;
            end
        end
    end

    assign move_l_o       = (state_q == DIR_L);
    assign move_r_o       = (state_q == DIR_R);
    assign jump_pulse_o   = jump_q;
    assign attack_pulse_o = attack_q;
    assign attack_ready_o = (cd_q == '0);

endmodule

// File: rtl/key_action_decoder.sv
// -----------------------------------------------------------------------------
// key_action_decoder
// Matches the keycode bus against a per-player keymap and drives one
// key_player_channel per player.
//   Clk   : system clock
//   Reset : synchronous active-high reset
//   bus   : key_action_decoder_if.slave (frame_tick, keycodes in; move_l,
//           move_r, jump_pulse, attack_pulse, attack_ready out)
// A keymap entry of 8'h00 disables that action, so empty slots never match.
// -----------------------------------------------------------------------------
module key_action_decoder
    import key_pkg::*;
#(
    parameter int                             NUM_PLAYERS     = 2,
    parameter int                             NUM_SLOTS       = 6,
    parameter int                             COOLDOWN_FRAMES = 15,
    parameter logic [NUM_PLAYERS*4*8-1:0]     KEYMAP          = DEFAULT_KEYMAP
) (
    input  logic          Clk,
    input  logic          Reset,
    key_action_decoder_if.slave bus
);

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [NUM_ACTIONS-1:0] hit;

        for (genvar ai = 0; ai < NUM_ACTIONS; ai++) begin : g_action
            localparam logic [7:0] ENTRY = KEYMAP[(gi*NUM_ACTIONS+ai)*8 +: 8];
            logic [NUM_SLOTS-1:0] slot_eq;

            for (genvar si = 0; si < NUM_SLOTS; si++) begin : g_slot
                assign slot_eq[si] = (bus.keycodes[si*8 +: 8] == ENTRY);
            end

            // OR-reduction makes duplicate keycodes count once.
            assign hit[ai] = (ENTRY != 8'h00) && (|slot_eq);
        end

        key_player_channel #(
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
        ) u_channel (
            .clk_i          (Clk),
            .srst_i         (Reset),
            .tick_i         (bus.frame_tick),
            .hit_i          (hit),
            .move_l_o       (bus.move_l[gi]),
            .move_r_o       (bus.move_r[gi]),
            .jump_pulse_o   (bus.jump_pulse[gi]),
            .attack_pulse_o (bus.attack_pulse[gi]),
            .attack_ready_o (bus.attack_ready[gi])
        );
    end

endmodule
